// File: rtl/inv_rr_sched.sv
// inv_rr_sched
// ------------
// Round-robin scheduler that shares a single 128-bit bitwise-invert datapath
// among NREQ requesters. On each cycle where the output slot is free, the
// first valid requester at or after the rotating pointer is granted. Its
// operand is inverted and registered into a single-entry output slot,
// together with the winner's ID.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Valid does not depend on ready. Ready may
// depend combinationally on valid. Here req_ready depends on req_valid,
// out_valid, out_ready and the pointer.
//
// Optional feature: define INV_RR_SCHED_PARITY_EN to add the out_par port.
// out_par is the registered even parity (XOR reduction) of out_data.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]      per-requester operand valid
//   req_data   in   [NREQ*128]  operands, lane i at [128*i +: 128]
//   req_ready  out  [NREQ]      per-requester accept (one-hot or zero)
//   out_valid  out              output slot holds a result
//   out_ready  in               consumer accepts the result
//   out_data   out  [128]       inverted operand of the winner
//   out_id     out  [IDW]       index of the requester that produced out_data
//   grant_cnt  out  [16]        count of accepted operands (wraps)
//   out_par    out              parity of out_data (INV_RR_SCHED_PARITY_EN only)

module inv_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*128-1:0]  req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data,
    output logic [IDW-1:0]       out_id,
    output logic [15:0]          grant_cnt
`ifdef INV_RR_SCHED_PARITY_EN
    ,
    output logic                 out_par
`endif
);

    // One extra bit so that ptr + offset cannot overflow before the modulo.
    localparam int IDXW = IDW + 1;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [127:0]    out_data_q, out_data_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic [15:0]     grant_cnt_q, grant_cnt_d;

    logic            slot_free;
    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [IDXW-1:0] scan_idx;
    logic [IDW-1:0]  scan_lane;
    logic            accept;
    logic [127:0]    win_inv;

    // The slot is free when empty or when it is being drained this cycle.
    assign slot_free = !out_valid_q || out_ready;

    // Rotating priority scan: lanes ptr, ptr+1, ... wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        scan_lane = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDXW'(ptr_q) + IDXW'(k);
            if (scan_idx >= IDXW'(NREQ)) begin
                scan_idx = scan_idx - IDXW'(NREQ);
            end
            scan_lane = scan_idx[IDW-1:0];
            if (!win_found && req_valid[scan_lane]) begin
                win_found = 1'b1;
                win_id    = scan_lane;
            end
        end
    end

    // No grant is offered while reset is asserted.
    assign accept    = rst_n && slot_free && win_found;
    assign req_ready = accept ? (NREQ'(1) << win_id) : '0;
    assign win_inv   = ~req_data[128*int'(win_id) +: 128];

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        grant_cnt_d = grant_cnt_q;
        if (accept) begin
            // Covers the simultaneous drain + reload case as well.
            out_valid_d = 1'b1;
            out_data_d  = win_inv;
            out_id_d    = win_id;
            grant_cnt_d = grant_cnt_q + 16'd1;
            ptr_d       = (int'(win_id) == NREQ - 1) ? '0 : win_id + IDW'(1);
        end else if (out_valid_q && out_ready) begin
            // Drain only: data and ID keep their last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            grant_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign grant_cnt = grant_cnt_q;

`ifdef INV_RR_SCHED_PARITY_EN
    logic out_par_q, out_par_d;

    always_comb begin
        out_par_d = out_par_q;
        if (accept) begin
            out_par_d = ^win_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
        end
    end

    assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_inv_rr_sched.sv
// Testbench for inv_rr_sched (NREQ = 4).
// Inputs change 1 time unit after a rising edge. Outputs are sampled 1 time
// unit later, after they have settled.

module tb_inv_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*128-1:0]  req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         out_data;
  logic [IDW-1:0]       out_id;
  logic [15:0]          grant_cnt;
`ifdef INV_RR_SCHED_PARITY_EN
  logic                 out_par;
`endif

  int checks = 0;
  int errors = 0;

  inv_rr_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .grant_cnt (grant_cnt)
`ifdef INV_RR_SCHED_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  // Each lane gets a distinct operand: the base value with the lane index
  // XORed into the top byte.
  function automatic logic [127:0] lane_val(input logic [127:0] base, input int i);
    return base ^ {8'(i), 120'h0};
  endfunction

  task automatic drive_lanes(input logic [127:0] base);
    for (int i = 0; i < NREQ; i++) req_data[128*i +: 128] = lane_val(base, i);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NREQ-1:0] rv;
    logic            ordy;
    logic [127:0]    base;
    logic [NREQ-1:0] exp_ready;
    logic            exp_valid;
    logic [IDW-1:0]  exp_id;
    logic [15:0]     exp_cnt;
  } vec_t;

  vec_t vecs[14];

  logic [127:0] exp_data;
  logic [15:0]  exp_cnt;
  logic [IDW-1:0] exp_id;
  int           n_fill;

  initial begin
    // Expected values below are worked out by hand from the pointer rules.
    vecs[0]  = '{4'b1111, 1'b1, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 4'b0001, 1'b1, 2'd0, 16'd1};
    vecs[1]  = '{4'b1111, 1'b1, 128'hdead_beef_0000_ffff_a5a5_5a5a_1234_5678, 4'b0010, 1'b1, 2'd1, 16'd2};
    vecs[2]  = '{4'b1111, 1'b1, 128'h0000_0000_0000_0000_0000_0000_0000_0000, 4'b0100, 1'b1, 2'd2, 16'd3};
    vecs[3]  = '{4'b1111, 1'b1, 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000, 4'b1000, 1'b1, 2'd3, 16'd4};
    vecs[4]  = '{4'b1111, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 4'b0001, 1'b1, 2'd0, 16'd5};
    vecs[5]  = '{4'b0001, 1'b1, 128'hcafe_f00d_cafe_f00d_cafe_f00d_cafe_f00d, 4'b0001, 1'b1, 2'd0, 16'd6};
    vecs[6]  = '{4'b1001, 1'b0, 128'h5555_5555_5555_5555_5555_5555_5555_5555, 4'b0000, 1'b1, 2'd0, 16'd6};
    vecs[7]  = '{4'b1001, 1'b1, 128'haaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa, 4'b1000, 1'b1, 2'd3, 16'd7};
    vecs[8]  = '{4'b0000, 1'b1, 128'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f, 4'b0000, 1'b0, 2'd3, 16'd7};
    vecs[9]  = '{4'b0110, 1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 4'b0010, 1'b1, 2'd1, 16'd8};
    vecs[10] = '{4'b0110, 1'b1, 128'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_fffe, 4'b0100, 1'b1, 2'd2, 16'd9};
    vecs[11] = '{4'b0011, 1'b1, 128'h0000_1111_0000_1111_0000_1111_0000_1111, 4'b0001, 1'b1, 2'd0, 16'd10};
    vecs[12] = '{4'b0000, 1'b0, 128'h1234_0000_0000_0000_0000_0000_0000_4321, 4'b0000, 1'b1, 2'd0, 16'd10};
    vecs[13] = '{4'b0000, 1'b1, 128'h9999_9999_9999_9999_9999_9999_9999_9999, 4'b0000, 1'b0, 2'd0, 16'd10};

    // ---------------- reset ----------------
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    out_ready = 1'b1;
    #2;
    check("reset_req_ready", req_ready, 0);
    step();
    step();
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data",  out_data,  0);
    check("reset_out_id",    out_id,    0);
    check("reset_grant_cnt", grant_cnt, 0);
    check("reset_req_ready_held", req_ready, 0);
    req_valid = '0;
    rst_n = 1'b1;
    step();

    // ---------------- table ----------------
    exp_data = '0;
    for (int v = 0; v < 14; v++) begin
      req_valid = vecs[v].rv;
      out_ready = vecs[v].ordy;
      drive_lanes(vecs[v].base);
      #1;
      check($sformatf("v%0d_req_ready", v), req_ready, vecs[v].exp_ready);
      if (vecs[v].exp_ready != '0) exp_data = ~lane_val(vecs[v].base, int'(vecs[v].exp_id));
      step();
      check($sformatf("v%0d_out_valid", v), out_valid, vecs[v].exp_valid);
      check($sformatf("v%0d_out_id", v),    out_id,    vecs[v].exp_id);
      check($sformatf("v%0d_grant_cnt", v), grant_cnt, vecs[v].exp_cnt);
      check($sformatf("v%0d_out_data", v),  out_data,  exp_data);
    end

    // ---------------- backpressure ----------------
    // Slot empty, pointer at 1: lane 1 wins and then the consumer stalls.
    req_valid = 4'b0011;
    out_ready = 1'b0;
    drive_lanes(128'h0bad_c0de_0bad_c0de_0bad_c0de_0bad_c0de);
    #1;
    check("bp_first_ready", req_ready, 4'b0010);
    exp_data = ~lane_val(128'h0bad_c0de_0bad_c0de_0bad_c0de_0bad_c0de, 1);
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_req_ready", c), req_ready, 0);
      check($sformatf("bp%0d_out_valid", c), out_valid, 1);
      check($sformatf("bp%0d_out_id", c),    out_id,    1);
      check($sformatf("bp%0d_out_data", c),  out_data,  exp_data);
      step();
    end
    // Release: pointer at 2 scans 2,3,0 so lane 0 is taken with no gap.
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 4'b0001);
    exp_data = ~lane_val(128'h0bad_c0de_0bad_c0de_0bad_c0de_0bad_c0de, 0);
    step();
    check("bp_release_valid", out_valid, 1);
    check("bp_release_id",    out_id,    0);
    check("bp_release_data",  out_data,  exp_data);
    check("bp_release_cnt",   grant_cnt, 12);

    // ---------------- reset mid-transfer ----------------
    req_valid = 4'b1111;
    out_ready = 1'b0;
    step();
    check("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data",  out_data,  0);
    check("mid_rst_id",    out_id,    0);
    check("mid_rst_cnt",   grant_cnt, 0);
    check("mid_rst_ready", req_ready, 0);
    step();
    rst_n = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    step();

    // ---------------- single requester after reset ----------------
    req_valid = 4'b0100;
    req_data  = '0;
    #1;
    check("single_ready", req_ready, 4'b0100);
    step();
    check("single_valid", out_valid, 1);
    check("single_data",  out_data,  {128{1'b1}});
    check("single_id",    out_id,    2);
    check("single_cnt",   grant_cnt, 1);

    // ---------------- grant counter wrap ----------------
    // All lanes valid and consumer always ready: one accept per cycle.
    req_valid = 4'b1111;
    exp_cnt   = 16'd1;
    n_fill    = 65535 - 1;
    for (int c = 0; c < n_fill; c++) step();
    exp_cnt = 16'hffff;
    check("wrap_cnt_max",   grant_cnt, exp_cnt);
    check("wrap_valid",     out_valid, 1);
    step();
    exp_cnt = exp_cnt + 16'd1;
    check("wrap_cnt_zero",  grant_cnt, 16'h0000);
    check("wrap_cnt_model", grant_cnt, exp_cnt);
    // 65535 accepts from pointer 3 (after lane 2): the last one lands on
    // lane (3 + 65534) mod 4 = 1, so pointer is now 2.
    exp_id = 2'd1;
    check("wrap_last_id", out_id, exp_id);

`ifdef INV_RR_SCHED_PARITY_EN
    // ---------------- parity ----------------
    req_valid = 4'b0001;
    req_data  = '0;
    req_data[127:0] = 128'h1;
    #1;
    check("par1_ready", req_ready, 4'b0001);
    step();
    check("par1_id",  out_id,  0);
    check("par1_par", out_par, 1);
    req_data[127:0] = 128'h3;
    step();
    check("par3_data", out_data, ~128'h3);
    check("par3_par",  out_par,  0);
    req_valid = '0;
    out_ready = 1'b0;
    step();
    check("par_hold", out_par, 0);
`endif

    req_valid = '0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
